horizon_spawner: RTL and testbench

Parametrised obstacle-queue scheduler for the runner game. It owns a ring buffer of SLOTS object slots and, on every frame update, decides whether to spawn a new object. It picks the new object's type under duplication and speed rules, pulses the slot update, and retires removed objects. It sits between the game controller (start/crash/update/speed) and an array of per-slot obstacle instances. It adds a true full/empty count, multi-slot retirement per frame, restart-after-crash, and a runtime minimum-speed table.

---
 rtl/horizon_spawner.sv | 254 +++++++++++++++++++++++++
 tb/tb_horizon_spawner.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/horizon_spawner.sv
// horizon_spawner
// Obstacle-queue scheduler for the runner game. Owns a ring buffer of SLOTS
// object slots. On every frame tick it decides whether to spawn a new
// object and which type to give it. It then retires finished objects from
// the front of the queue.
//
// Optional feature macro: SPAWN_STATS_EN. When it is defined, the module
// adds spawn_total_o, a 16-bit saturating count of committed allocations.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   update_i              one-cycle frame tick (only honoured in RUN)
//   start_i               start the game, or restart from CRASHED
//   crash_i               collision detected
//   speed_i               current speed, fixed point scaled by SPEED_SCALE
//   rng_data_i            random value used to pick the spawn type
//   spawn_en_i            allow new spawns
//   type_min_speed_i      minimum integer speed per type (index t-1 = type t)
//   slot_visible_i        per-slot: object is on screen
//   slot_remove_i         per-slot: object has finished
//   slot_x_i              per-slot signed x position
//   slot_width_i          per-slot width
//   slot_gap_i            per-slot required gap after the object
//   slot_start_o          per-slot active flag
//   slot_type_o           per-slot type code (0 = NONE)
//   slot_update_o         update pulse to all slots, high during SPAWN
//   count_o               number of occupied slots
//   busy_o                high while a frame is being processed
//   spawn_drop_o          pulse: a spawn was wanted but the queue was full
//   spawn_total_o         (SPAWN_STATS_EN only) committed allocation count
module horizon_spawner #(
    parameter int SLOTS       = 7,
    parameter int TYPES       = 3,
    parameter int MAX_DUP     = 2,
    parameter int GAME_WIDTH  = 600,
    parameter int SPEED_SCALE = 1024,
    parameter int X_W         = 11,
    localparam int TW  = $clog2(TYPES + 1),
    localparam int CW  = $clog2(SLOTS + 1),
    localparam int IW  = $clog2(SLOTS),
    localparam int TIW = (TYPES > 1) ? $clog2(TYPES) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      update_i,
    input  logic                      start_i,
    input  logic                      crash_i,
    input  logic [14:0]               speed_i,
    input  logic [10:0]               rng_data_i,
    input  logic                      spawn_en_i,
    input  logic [TYPES-1:0][3:0]     type_min_speed_i,
    input  logic [SLOTS-1:0]          slot_visible_i,
    input  logic [SLOTS-1:0]          slot_remove_i,
    input  logic [SLOTS-1:0][X_W-1:0] slot_x_i,
    input  logic [SLOTS-1:0][9:0]     slot_width_i,
    input  logic [SLOTS-1:0][10:0]    slot_gap_i,
    output logic [SLOTS-1:0]          slot_start_o,
    output logic [SLOTS-1:0][TW-1:0]  slot_type_o,
    output logic                      slot_update_o,
    output logic [CW-1:0]             count_o,
    output logic                      busy_o,
`ifdef SPAWN_STATS_EN
    output logic [15:0]               spawn_total_o,
`endif
    output logic                      spawn_drop_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_SPAWN, S_WAIT, S_RETIRE, S_CRASHED
    } state_t;

    localparam logic signed [X_W+1:0] GW = (X_W + 2)'(GAME_WIDTH);

    state_t                    state_q, state_d;
    logic [IW-1:0]             front_q, front_d, back_q, back_d;
    logic [CW-1:0]             count_q, count_d;
    logic [SLOTS-1:0]          slotStart_q, slotStart_d;
    logic [SLOTS-1:0][TW-1:0]  slotType_q, slotType_d;
    logic                      slotUpdate_q;
    logic                      spawnDrop_q, spawnDrop_d;

    logic [IW-1:0]             lastIdx;
    logic signed [X_W+1:0]     xExt, wExt, gExt, lastEnd;
    logic                      spawnWanted;
    logic                      typeFound;
    logic [TW-1:0]             pickType;
    logic                      dupOk, allSame, speedOk;
    int                        cand;
    int                        speedInt;

    // Ring indices wrap at SLOTS, which need not be a power of two.
    function automatic logic [IW-1:0] incIdx(input logic [IW-1:0] idx);
        return (idx == IW'(SLOTS - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Spawn evaluation. The end of the newest object is summed two bits wider
    // than the x position so that it cannot wrap. The candidate types are
    // then walked in rng order, and the first one that passes both the
    // duplicate rule and the speed rule is chosen.
    always_comb begin
        lastIdx     = (back_q == '0) ? IW'(SLOTS - 1) : back_q - 1'b1;
        xExt        = (X_W + 2)'($signed(slot_x_i[lastIdx]));
        wExt        = (X_W + 2)'(slot_width_i[lastIdx]);
        gExt        = (X_W + 2)'(slot_gap_i[lastIdx]);
        lastEnd     = xExt + wExt + gExt;
        spawnWanted = spawn_en_i &&
                      ((count_q == '0) || (slot_visible_i[lastIdx] && (lastEnd < GW)));

        speedInt  = int'(speed_i) / SPEED_SCALE;
        typeFound = 1'b0;
        pickType  = '0;
        cand      = 0;
        dupOk     = 1'b0;
        allSame   = 1'b0;
        speedOk   = 1'b0;
        for (int i = 0; i < TYPES; i++) begin
            cand    = ((int'(rng_data_i) + i) % TYPES) + 1;
            dupOk   = (int'(count_q) < MAX_DUP);
            if (!dupOk) begin
                allSame = 1'b1;
                for (int k = 1; k <= MAX_DUP; k++) begin
                    if (int'(slotType_q[IW'((int'(back_q) + SLOTS - k) % SLOTS)]) != cand) begin
                        allSame = 1'b0;
                    end
                end
                dupOk = !allSame;
            end
            speedOk = speedInt >= int'(type_min_speed_i[TIW'(cand - 1)]);
            if (!typeFound && dupOk && speedOk) begin
                typeFound = 1'b1;
                pickType  = TW'(cand);
            end
        end
    end

    // Frame sequencer and queue bookkeeping. A crash wins over any spawn or
    // retire that would otherwise commit in the same cycle.
    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        back_d      = back_q;
        count_d     = count_q;
        slotStart_d = slotStart_q;
        slotType_d  = slotType_q;
        spawnDrop_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (crash_i)       state_d = S_CRASHED;
                else if (update_i) state_d = S_SPAWN;
            end
            S_SPAWN: begin
                if (crash_i) begin
                    state_d = S_CRASHED;
                end else begin
                    state_d = S_WAIT;
                    if (spawnWanted) begin
                        if (count_q == CW'(SLOTS)) begin
                            spawnDrop_d = 1'b1;
                        end else if (typeFound) begin
                            slotType_d[back_q]  = pickType;
                            slotStart_d[back_q] = 1'b1;
                            back_d              = incIdx(back_q);
                            count_d             = count_q + 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                state_d = crash_i ? S_CRASHED : S_RETIRE;
            end
            S_RETIRE: begin
                if (crash_i) begin
                    state_d = S_CRASHED;
                end else if ((count_q != '0) && slot_remove_i[front_q]) begin
                    slotStart_d[front_q] = 1'b0;
                    slotType_d[front_q]  = '0;
                    front_d              = incIdx(front_q);
                    count_d              = count_q - 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_CRASHED: begin
                if (start_i) begin
                    state_d     = S_RUN;
                    front_d     = '0;
                    back_d      = '0;
                    count_d     = '0;
                    slotStart_d = '0;
                    slotType_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and queue registers. slot_update is registered from the next
    // state, so it is high exactly while the sequencer sits in SPAWN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            front_q      <= '0;
            back_q       <= '0;
            count_q      <= '0;
            slotStart_q  <= '0;
            slotType_q   <= '0;
            slotUpdate_q <= 1'b0;
            spawnDrop_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            back_q       <= back_d;
            count_q      <= count_d;
            slotStart_q  <= slotStart_d;
            slotType_q   <= slotType_d;
            slotUpdate_q <= (state_d == S_SPAWN);
            spawnDrop_q  <= spawnDrop_d;
        end
    end

`ifdef SPAWN_STATS_EN
    logic [15:0] spawnTotal_q;
    logic        allocCommit;
    logic        restartCommit;

    // In SPAWN, back only moves when an allocation commits.
    assign allocCommit   = (state_q == S_SPAWN) && (back_d != back_q);
    assign restartCommit = (state_q == S_CRASHED) && start_i;

    // Saturating allocation counter, cleared on restart.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spawnTotal_q <= '0;
        end else if (restartCommit) begin
            spawnTotal_q <= '0;
        end else if (allocCommit && (spawnTotal_q != 16'hFFFF)) begin
            spawnTotal_q <= spawnTotal_q + 16'd1;
        end
    end

    assign spawn_total_o = spawnTotal_q;
`endif

    assign slot_start_o  = slotStart_q;
    assign slot_type_o   = slotType_q;
    assign slot_update_o = slotUpdate_q;
    assign count_o       = count_q;
    assign spawn_drop_o  = spawnDrop_q;
    assign busy_o        = (state_q == S_SPAWN) || (state_q == S_WAIT) || (state_q == S_RETIRE);

endmodule

// File: tb/tb_horizon_spawner.sv
// tb_horizon_spawner
// Directed bench for horizon_spawner. A queue-based game model predicts the
// slot contents, count and pulses on every cycle. Hand-computed literal
// expectations pin the model at the interesting points.
module tb_horizon_spawner;

    localparam int SLOTS       = 7;
    localparam int TYPES       = 3;
    localparam int MAX_DUP     = 2;
    localparam int GAME_WIDTH  = 600;
    localparam int SPEED_SCALE = 1024;
    localparam int X_W         = 11;
    localparam int TW          = 2;
    localparam int CW          = 3;
    localparam int IW          = 3;

    logic                      clk_i = 1'b0;
    logic                      rst_i = 1'b1;
    logic                      update_i = 1'b0;
    logic                      start_i = 1'b0;
    logic                      crash_i = 1'b0;
    logic [14:0]               speed_i = '0;
    logic [10:0]               rng_data_i = '0;
    logic                      spawn_en_i = 1'b0;
    logic [TYPES-1:0][3:0]     type_min_speed_i = '0;
    logic [SLOTS-1:0]          slot_visible_i = '0;
    logic [SLOTS-1:0]          slot_remove_i = '0;
    logic [SLOTS-1:0][X_W-1:0] slot_x_i = '0;
    logic [SLOTS-1:0][9:0]     slot_width_i = '0;
    logic [SLOTS-1:0][10:0]    slot_gap_i = '0;
    logic [SLOTS-1:0]          slot_start_o;
    logic [SLOTS-1:0][TW-1:0]  slot_type_o;
    logic                      slot_update_o;
    logic [CW-1:0]             count_o;
    logic                      busy_o;
    logic                      spawn_drop_o;

    int checks   = 0;
    int failures = 0;
    bit cmpOn    = 1'b0;

    horizon_spawner dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .update_i         (update_i),
        .start_i          (start_i),
        .crash_i          (crash_i),
        .speed_i          (speed_i),
        .rng_data_i       (rng_data_i),
        .spawn_en_i       (spawn_en_i),
        .type_min_speed_i (type_min_speed_i),
        .slot_visible_i   (slot_visible_i),
        .slot_remove_i    (slot_remove_i),
        .slot_x_i         (slot_x_i),
        .slot_width_i     (slot_width_i),
        .slot_gap_i       (slot_gap_i),
        .slot_start_o     (slot_start_o),
        .slot_type_o      (slot_type_o),
        .slot_update_o    (slot_update_o),
        .count_o          (count_o),
        .busy_o           (busy_o),
        .spawn_drop_o     (spawn_drop_o)
    );

    always #5 clk_i = ~clk_i;

    // Game model. mode: 0 idle, 1 playing, 2 crashed. step within a frame:
    // 0 waiting for tick, 1 spawning, 2 waiting, 3 retiring.
    // mHist holds the queued types from oldest to newest.
    int mMode;
    int mStep;
    int mHead;
    int mTail;
    int mTypes[SLOTS];
    bit mStart[SLOTS];
    int mHist[$];
    bit mUpd;
    bit mDrop;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelSpawn();
        int  n;
        int  last;
        int  endX;
        int  t;
        int  pick;
        bit  want;
        bit  dup;
        n    = mHist.size();
        last = (mTail + SLOTS - 1) % SLOTS;
        endX = int'($signed(slot_x_i[IW'(last)])) + int'(slot_width_i[IW'(last)])
             + int'(slot_gap_i[IW'(last)]);
        want = spawn_en_i && ((n == 0) || (slot_visible_i[IW'(last)] && (endX < GAME_WIDTH)));
        if (!want) return;
        if (n == SLOTS) begin
            mDrop = 1'b1;
            return;
        end
        pick = 0;
        for (int i = 0; i < TYPES; i++) begin
            t   = ((int'(rng_data_i) + i) % TYPES) + 1;
            dup = (n >= MAX_DUP);
            if (dup) begin
                for (int j = n - MAX_DUP; j < n; j++) begin
                    if (mHist[j] != t) dup = 1'b0;
                end
            end
            if ((pick == 0) && !dup &&
                ((int'(speed_i) / SPEED_SCALE) >= int'(type_min_speed_i[2'(t - 1)]))) begin
                pick = t;
            end
        end
        if (pick != 0) begin
            mTypes[mTail] = pick;
            mStart[mTail] = 1'b1;
            mHist.push_back(pick);
            mTail = (mTail + 1) % SLOTS;
        end
    endtask

    // Advance the model on every clock edge and reset it asynchronously.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mMode = 0;
            mStep = 0;
            mHead = 0;
            mTail = 0;
            mHist.delete();
            mUpd  = 1'b0;
            mDrop = 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                mTypes[s] = 0;
                mStart[s] = 1'b0;
            end
        end else begin
            mDrop = 1'b0;
            if (mMode == 0) begin
                if (start_i) mMode = 1;
            end else if (mMode == 2) begin
                if (start_i) begin
                    mMode = 1;
                    mStep = 0;
                    mHead = 0;
                    mTail = 0;
                    mHist.delete();
                    for (int s = 0; s < SLOTS; s++) begin
                        mTypes[s] = 0;
                        mStart[s] = 1'b0;
                    end
                end
            end else if (crash_i) begin
                mMode = 2;
            end else begin
                case (mStep)
                    0: if (update_i) mStep = 1;
                    1: begin
                        modelSpawn();
                        mStep = 2;
                    end
                    2: mStep = 3;
                    default: begin
                        if ((mHist.size() > 0) && slot_remove_i[IW'(mHead)]) begin
                            mTypes[mHead] = 0;
                            mStart[mHead] = 1'b0;
                            void'(mHist.pop_front());
                            mHead = (mHead + 1) % SLOTS;
                        end else begin
                            mStep = 0;
                        end
                    end
                endcase
            end
            mUpd = (mMode == 1) && (mStep == 1);
        end
    end

    // Compare the DUT against the model on every falling edge.
    logic [SLOTS-1:0]         expStart;
    logic [SLOTS-1:0][TW-1:0] expType;
    always @(negedge clk_i) begin
        if (cmpOn) begin
            for (int s = 0; s < SLOTS; s++) begin
                expStart[s] = mStart[s];
                expType[s]  = TW'(mTypes[s]);
            end
            checkOutput("model_start",  32'(slot_start_o),  32'(expStart));
            checkOutput("model_type",   32'(slot_type_o),   32'(expType));
            checkOutput("model_count",  32'(count_o),       32'(mHist.size()));
            checkOutput("model_update", 32'(slot_update_o), 32'(mUpd));
            checkOutput("model_drop",   32'(spawn_drop_o),  32'(mDrop));
            checkOutput("model_busy",   32'(busy_o),        32'((mMode == 1) && (mStep != 0)));
        end
    end

    task automatic applyStimulus(input logic u, input logic s, input logic c);
        update_i = u;
        start_i  = s;
        crash_i  = c;
        @(negedge clk_i);
        update_i = 1'b0;
        start_i  = 1'b0;
        crash_i  = 1'b0;
    endtask

    task automatic waitFrameDone();
        int cyc = 0;
        while ((busy_o !== 1'b0) && (cyc < 40)) begin
            @(negedge clk_i);
            cyc++;
        end
        checkOutput("frame_done", 32'(busy_o), 32'd0);
    endtask

    task automatic doFrame();
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitFrameDone();
    endtask

    task automatic setSlot(input int idx, input logic vis, input int x, input int w, input int g);
        slot_visible_i[IW'(idx)] = vis;
        slot_x_i[IW'(idx)]       = X_W'(x);
        slot_width_i[IW'(idx)]   = 10'(w);
        slot_gap_i[IW'(idx)]     = 11'(g);
    endtask

    initial begin
        @(negedge clk_i);
        cmpOn = 1'b1;
        checkOutput("reset_count", 32'(count_o), 32'd0);
        checkOutput("reset_start", 32'(slot_start_o), 32'd0);
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        spawn_en_i = 1'b1;

        // First spawn into an empty queue.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("spawn_update_hi", 32'(slot_update_o), 32'd1);
        checkOutput("spawn_busy", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        checkOutput("first_update_lo", 32'(slot_update_o), 32'd0);
        checkOutput("first_type", 32'(slot_type_o[0]), 32'd1);
        checkOutput("first_start", 32'(slot_start_o[0]), 32'd1);
        checkOutput("first_count", 32'(count_o), 32'd1);
        waitFrameDone();

        // Spawn threshold: 610 blocks, 590 allows.
        setSlot(0, 1'b1, 500, 50, 60);
        doFrame();
        checkOutput("gap_block_count", 32'(count_o), 32'd1);
        setSlot(0, 1'b1, 480, 50, 60);
        doFrame();
        checkOutput("gap_ok_count", 32'(count_o), 32'd2);
        checkOutput("gap_ok_type", 32'(slot_type_o[1]), 32'd1);

        // Duplicate rule, then speed rule.
        for (int s = 0; s < SLOTS; s++) setSlot(s, 1'b1, 0, 0, 0);
        doFrame();
        checkOutput("dup_type", 32'(slot_type_o[2]), 32'd2);
        rng_data_i = 11'd1;
        type_min_speed_i[1] = 4'd9;
        speed_i = 15'd8192;
        doFrame();
        checkOutput("speed_type", 32'(slot_type_o[3]), 32'd3);
        checkOutput("speed_count", 32'(count_o), 32'd4);
        rng_data_i = '0;
        type_min_speed_i = '0;
        speed_i = '0;

        // Fill to capacity, then a wanted spawn is dropped.
        repeat (3) doFrame();
        checkOutput("full_count", 32'(count_o), 32'd7);
        checkOutput("full_start", 32'(slot_start_o), 32'h7F);
        checkOutput("full_type6", 32'(slot_type_o[6]), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        checkOutput("drop_pulse", 32'(spawn_drop_o), 32'd1);
        checkOutput("drop_count", 32'(count_o), 32'd7);
        @(negedge clk_i);
        checkOutput("drop_clear", 32'(spawn_drop_o), 32'd0);
        waitFrameDone();
        checkOutput("drop_type0", 32'(slot_type_o[0]), 32'd1);

        // Retire two slots, wrap an allocation, then drain everything.
        spawn_en_i = 1'b0;
        slot_remove_i = 7'b0000011;
        doFrame();
        checkOutput("retire_count", 32'(count_o), 32'd5);
        checkOutput("retire_start", 32'(slot_start_o), 32'b1111100);
        checkOutput("retire_type01", 32'(slot_type_o[1:0]), 32'd0);
        slot_remove_i = '0;
        spawn_en_i = 1'b1;
        doFrame();
        checkOutput("wrap_type0", 32'(slot_type_o[0]), 32'd1);
        checkOutput("wrap_count", 32'(count_o), 32'd6);
        spawn_en_i = 1'b0;
        slot_remove_i = '1;
        doFrame();
        checkOutput("drain_count", 32'(count_o), 32'd0);
        checkOutput("drain_start", 32'(slot_start_o), 32'd0);
        slot_remove_i = '0;

        // Crash during WAIT freezes the slots; restart clears them.
        spawn_en_i = 1'b1;
        doFrame();
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("crash_busy", 32'(busy_o), 32'd0);
        checkOutput("crash_count", 32'(count_o), 32'd2);
        checkOutput("crash_start", 32'(slot_start_o), 32'b0000110);
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk_i);
        checkOutput("crashed_hold_count", 32'(count_o), 32'd2);
        checkOutput("crashed_no_update", 32'(slot_update_o), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("restart_count", 32'(count_o), 32'd0);
        checkOutput("restart_start", 32'(slot_start_o), 32'd0);
        checkOutput("restart_type", 32'(slot_type_o), 32'd0);

        // Crash during SPAWN commits nothing.
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("spawn_crash_count", 32'(count_o), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of SPAWN.
        applyStimulus(1'b1, 1'b0, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("async_busy", 32'(busy_o), 32'd0);
        checkOutput("async_count", 32'(count_o), 32'd0);
        checkOutput("async_update", 32'(slot_update_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        checkOutput("idle_ignore_update", 32'(busy_o), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        doFrame();
        checkOutput("post_reset_type0", 32'(slot_type_o[0]), 32'd1);
        checkOutput("post_reset_count", 32'(count_o), 32'd1);

        @(negedge clk_i);
        cmpOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
